fifo_uart_tx: RTL and testbench
===============================

Name: fifo_uart_tx

Overview:
- Downstream consumer of the polling controller's sample FIFO (8-bit, normal/non-show-ahead read mode).
- Pops one byte at a time via rdreq/empty/q and serialises it as 8N1 UART on txd, LSB first.
- Carries AD bytes and the 0x0d/0x0a line terminators to the host.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- BAUD_DIV, CLK_FREQ/BAUD (434), clocks per bit; legal range 2..65535; overridable directly for simulation.

Ports:
- clk  input  1  system clock, 50 MHz.
- reset_n  input  1  synchronous reset, active-low.
- tx_en  input  1  1 = allowed to start new frames; 0 = finish current frame, then hold idle.
- fifo_empty  input  1  FIFO empty flag.
- fifo_q  input  8  FIFO read data; valid the clock after fifo_rdreq.
- fifo_rdreq  output  1  one-clock FIFO read strobe.
- txd  output  1  UART serial out; idle high.
- busy  output  1  high from READ through end of STOP.
- byte_done  output  1  one-clock pulse on the last clock of each stop bit.

Behaviour:
- Single clock domain (clk). reset_n is synchronous active-low, sampled only on the rising edge of clk.
- Reset values: state IDLE; txd=1; fifo_rdreq=0; busy=0; byte_done=0; baud_cnt=0; bit_cnt=0; shift register 0x00.
- All outputs are registered Moore outputs; no combinational input-to-output paths.
- State machine:
  - IDLE: txd=1. If tx_en=1 and fifo_empty=0, go to READ; otherwise stay.
  - READ: exactly one clock with fifo_rdreq=1; go to LATCH.
  - LATCH: one clock; capture fifo_q into the shift register; go to START.
  - START: txd=0 for BAUD_DIV clocks.
  - DATA: txd = shift register bit 0 for BAUD_DIV clocks per bit. Shift right after each bit. bit_cnt counts 0..7; after bit 7 go to STOP.
  - STOP: txd=1 for BAUD_DIV clocks; byte_done=1 on the final clock.
  - Leaving STOP: go to READ if tx_en=1 and fifo_empty=0, else IDLE.
- Baud counter: 16-bit, counts 0..BAUD_DIV-1. Clears on entry to START, DATA and STOP and on each DATA bit boundary.
- Latency: IDLE sees the start condition at edge N. Then fifo_rdreq is high in cycle N+1, data is latched at N+2, and txd falls at N+3.
- A frame is exactly 10*BAUD_DIV clocks of START+DATA+STOP.
- Back-to-back bytes: the stop bit is extended by 2 clocks (READ+LATCH, txd=1). Inter-frame gap is therefore BAUD_DIV+2 clocks high.
- fifo_rdreq is never asserted when fifo_empty=1. fifo_empty is sampled only in IDLE and on the last STOP clock. At most one rdreq per frame.
- tx_en deasserted mid-frame: the current frame completes unchanged and no further rdreq is issued. Re-asserting tx_en resumes from IDLE.
- Reset mid-frame: on the next edge txd=1 and state IDLE; the partial byte is discarded and not re-read. rdreq is not asserted during reset.
- fifo_full is not used. Data overrun is the writer's responsibility.

Test Plan:
1. BAUD_DIV=4; FIFO holds 0x55; tx_en=1 -> rdreq high for 1 clock; txd falls 3 clocks after empty is seen low. txd sequence is 0,1,0,1,0,1,0,1,0,1, each bit 4 clocks. byte_done pulses once at clock 40 after the start bit; busy=0 afterwards.
2. BAUD_DIV=4; FIFO holds 0x41,0x0d,0x0a -> three frames decode as 0x41,0x0d,0x0a. Exactly 3 rdreq pulses; each inter-frame high gap is 6 clocks; 3 byte_done pulses.
3. fifo_empty=1 for 1000 clocks with tx_en=1 -> fifo_rdreq never asserted; txd=1; busy=0.
4. tx_en dropped during DATA bit 3 of 0xA5 with 2 more bytes queued -> 0xA5 completes correctly; no rdreq follows. Re-raising tx_en sends the next byte.
5. reset_n=0 for 1 clock during DATA bit 5 -> next edge txd=1, busy=0, rdreq=0, byte_done=0. After release with a non-empty FIFO, the next byte is sent from a clean start bit.
6. Default parameters (BAUD_DIV=434) with byte 0x00 -> start plus 8 data bits give 3906 clocks low, then 434 clocks high; byte_done is high on the last stop clock.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains an 8-bit normal-mode (non-show-ahead) FIFO one byte at a
// time and sends each byte as 8N1 UART on txd, LSB first.
//
// Ports:
//   clk         system clock
//   reset_n     synchronous active-low reset
//   tx_en       1 = new frames may start; 0 = finish the current frame, then idle
//   fifo_empty  FIFO empty flag
//   fifo_q      FIFO read data, valid the clock after fifo_rdreq
//   fifo_rdreq  one-clock FIFO read strobe
//   txd         serial output, idle high
//   busy        high from the read strobe through the end of the stop bit
//   byte_done   one-clock pulse on the last clock of each stop bit
module fifo_uart_tx #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 115200,
  parameter int unsigned BAUD_DIV = CLK_FREQ / BAUD
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tx_en,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_q,
  output logic       fifo_rdreq,
  output logic       txd,
  output logic       busy,
  output logic       byte_done
);

  localparam logic [15:0] BaudLast = 16'(BAUD_DIV - 1);
  localparam logic [15:0] BaudPen  = 16'(BAUD_DIV - 2);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StLatch,
    StStart,
    StData,
    StStop
  } state_e;

  state_e      state_q;
  logic [15:0] baud_cnt_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  shift_q;

  logic start_ok;
  logic baud_end;

  // fifo_empty only matters where it is consulted: in idle and on the last stop clock.
  assign start_ok = tx_en && !fifo_empty;
  assign baud_end = (baud_cnt_q == BaudLast);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      baud_cnt_q <= 16'd0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      fifo_rdreq <= 1'b0;
      txd        <= 1'b1;
      busy       <= 1'b0;
      byte_done  <= 1'b0;
    end else begin
      fifo_rdreq <= 1'b0;
      byte_done  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          txd <= 1'b1;
          if (start_ok) begin
            state_q    <= StRead;
            fifo_rdreq <= 1'b1;
            busy       <= 1'b1;
          end
        end
        StRead: begin
          state_q <= StLatch;
        end
        StLatch: begin
          // Normal-mode FIFO: q became valid the clock after the read strobe.
          shift_q    <= fifo_q;
          txd        <= 1'b0;
          baud_cnt_q <= 16'd0;
          state_q    <= StStart;
        end
        StStart: begin
          if (baud_end) begin
            baud_cnt_q <= 16'd0;
            bit_cnt_q  <= 3'd0;
            txd        <= shift_q[0];
            state_q    <= StData;
          end else begin
            baud_cnt_q <= baud_cnt_q + 16'd1;
          end
        end
        StData: begin
          if (baud_end) begin
            baud_cnt_q <= 16'd0;
            shift_q    <= {1'b0, shift_q[7:1]};
            if (bit_cnt_q == 3'd7) begin
              txd     <= 1'b1;
              state_q <= StStop;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              // Next bit is shift_q[1] before the shift takes effect.
              txd       <= shift_q[1];
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 16'd1;
          end
        end
        StStop: begin
          if (baud_end) begin
            baud_cnt_q <= 16'd0;
            if (start_ok) begin
              // Back-to-back: READ and LATCH extend the stop bit by two clocks.
              state_q    <= StRead;
              fifo_rdreq <= 1'b1;
            end else begin
              state_q <= StIdle;
              busy    <= 1'b0;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 16'd1;
            // Registered: raised one clock early so it is high on the final stop clock.
            byte_done  <= (baud_cnt_q == BaudPen);
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a FIFO model feeds a BAUD_DIV=4 instance, a UART
// receiver decodes txd into a scoreboard, and a default-parameter instance
// checks full-rate bit timing.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

  localparam int Div = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       tx_en;
  logic       fifo_empty;
  logic [7:0] fifo_q = 8'h00;
  logic       fifo_rdreq;
  logic       txd;
  logic       busy;
  logic       byte_done;

  logic       d_tx_en;
  logic       d_fifo_empty;
  logic [7:0] d_fifo_q = 8'h00;
  logic       d_rdreq;
  logic       d_txd;
  logic       d_busy;
  logic       d_done;

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .BAUD_DIV(Div)
  ) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .tx_en     (tx_en),
    .fifo_empty(fifo_empty),
    .fifo_q    (fifo_q),
    .fifo_rdreq(fifo_rdreq),
    .txd       (txd),
    .busy      (busy),
    .byte_done (byte_done)
  );

  fifo_uart_tx u_dut_def (
    .clk       (clk),
    .reset_n   (reset_n),
    .tx_en     (d_tx_en),
    .fifo_empty(d_fifo_empty),
    .fifo_q    (d_fifo_q),
    .fifo_rdreq(d_rdreq),
    .txd       (d_txd),
    .busy      (d_busy),
    .byte_done (d_done)
  );

  // FIFO model: written by the stimulus, popped on rdreq with one clock of latency.
  logic [7:0] fifo_mem [0:63];
  int n_push = 0;
  int n_pop  = 0;
  assign fifo_empty = (n_push == n_pop);

  always @(posedge clk) begin
    if (fifo_rdreq && !fifo_empty) begin
      fifo_q <= fifo_mem[n_pop[5:0]];
      n_pop  <= n_pop + 1;
    end
  end

  // Event counters.
  int n_rdreq  = 0;
  int n_done   = 0;
  int n_bad_rd = 0;
  always @(posedge clk) begin
    if (fifo_rdreq) n_rdreq <= n_rdreq + 1;
    if (byte_done) n_done <= n_done + 1;
    if (fifo_rdreq && fifo_empty) n_bad_rd <= n_bad_rd + 1;
  end

  // UART receiver: samples each bit in its third clock; aborts a frame on reset.
  logic [7:0] rx_mem  [0:63];
  logic       rx_ferr [0:63];
  int         n_rx     = 0;
  logic       rx_act   = 1'b0;
  int         rx_tick  = 0;
  logic [7:0] rx_shift = 8'h00;
  logic       rx_bad   = 1'b0;

  always @(negedge clk) begin
    if (!reset_n) begin
      rx_act <= 1'b0;
    end else if (!rx_act) begin
      if (txd === 1'b0) begin
        rx_act  <= 1'b1;
        rx_tick <= 1;
        rx_bad  <= 1'b0;
      end
    end else begin
      rx_tick <= rx_tick + 1;
      if (((rx_tick + 1) % Div) == (Div / 2 + 1)) begin
        if (((rx_tick + 1) / Div) == 0) begin
          rx_bad <= (txd !== 1'b0);
        end else if (((rx_tick + 1) / Div) <= 8) begin
          rx_shift <= {txd, rx_shift[7:1]};
        end else begin
          rx_mem[n_rx[5:0]]  <= rx_shift;
          rx_ferr[n_rx[5:0]] <= rx_bad | (txd !== 1'b1);
          n_rx   <= n_rx + 1;
          rx_act <= 1'b0;
        end
      end
    end
  end

  // Scoreboard and checking.
  logic [7:0] exp_q [$];
  int rx_rd = 0;
  int n_cmp = 0;
  int n_err = 0;
  logic tr [0:199];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b, input bit expect_tx);
    fifo_mem[n_push[5:0]] = b;
    n_push++;
    if (expect_tx) exp_q.push_back(b);
  endtask

  task automatic expect_frames(input string tag, input int n, input int budget);
    int t;
    logic [7:0] e;
    t = 0;
    while ((n_rx - rx_rd) < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_nframes"}, n_rx - rx_rd, n);
    for (int i = 0; i < n && rx_rd < n_rx; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      check({tag, "_byte"}, {24'd0, rx_mem[rx_rd[5:0]]}, {24'd0, e});
      check({tag, "_framing"}, {31'd0, rx_ferr[rx_rd[5:0]]}, 32'd0);
      rx_rd++;
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return b[idx-1];
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0, dn0, t, lows, bhi, run, n6, odd, hi;
    bit seen_low;
    logic exp_txd;

    reset_n      = 1'b0;
    tx_en        = 1'b0;
    d_tx_en      = 1'b0;
    d_fifo_empty = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1);
    check("rst_rdreq", fifo_rdreq, 0);
    check("rst_busy", busy, 0);
    check("rst_done", byte_done, 0);
    check("rst_def_txd", d_txd, 1);
    check("rst_def_busy", d_busy, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tx_en   = 1'b1;
    repeat (3) @(negedge clk);

    // 1: single byte 0x55, cycle-exact
    rd0 = n_rdreq;
    push(8'h55, 1'b1);
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      exp_txd = (k < 3 || k > 42) ? 1'b1 : frame_bit(8'h55, (k - 3) / Div);
      check("t1_txd", txd, exp_txd);
      check("t1_rdreq", fifo_rdreq, (k == 1));
      check("t1_done", byte_done, (k == 42));
      check("t1_busy", busy, (k >= 1 && k <= 42));
    end
    check("t1_rdreq_count", n_rdreq - rd0, 1);
    expect_frames("t1", 1, 20);

    // 2: back-to-back 0x41 0x0d 0x0a
    rd0 = n_rdreq;
    dn0 = n_done;
    push(8'h41, 1'b1);
    push(8'h0d, 1'b1);
    push(8'h0a, 1'b1);
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      tr[k] = txd;
    end
    run = 0; n6 = 0; odd = 0; seen_low = 1'b0;
    for (int k = 0; k < 150; k++) begin
      if (tr[k] === 1'b1) begin
        run++;
      end else begin
        if (seen_low && run == 6) n6++;
        if (seen_low && run != 0 && run != 6 && (run % Div) != 0) odd++;
        run = 0;
        seen_low = 1'b1;
      end
    end
    check("t2_gaps6", n6, 2);
    check("t2_odd_runs", odd, 0);
    check("t2_rdreq_count", n_rdreq - rd0, 3);
    check("t2_done_count", n_done - dn0, 3);
    expect_frames("t2", 3, 100);

    // 3: empty FIFO held for 1000 clocks
    rd0 = n_rdreq;
    lows = 0;
    bhi = 0;
    repeat (1000) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
      if (busy !== 1'b0) bhi++;
    end
    check("t3_txd_low", lows, 0);
    check("t3_busy", bhi, 0);
    check("t3_rdreq", n_rdreq - rd0, 0);

    // 4: tx_en dropped during data bit 3 of 0xA5
    rd0 = n_rdreq;
    dn0 = n_done;
    push(8'ha5, 1'b1);
    push(8'h11, 1'b1);
    push(8'h22, 1'b1);
    repeat (20) @(negedge clk);
    tx_en = 1'b0;
    t = 0;
    while (n_done == dn0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (30) @(negedge clk);
    check("t4_rdreq_after_stop", n_rdreq - rd0, 1);
    check("t4_busy_idle", busy, 0);
    check("t4_txd_idle", txd, 1);
    expect_frames("t4a", 1, 10);
    tx_en = 1'b1;
    expect_frames("t4b", 2, 300);
    check("t4_rdreq_total", n_rdreq - rd0, 3);
    repeat (10) @(negedge clk);

    // 5: one-clock reset during data bit 5 of 0x3C, then 0x96 follows
    rd0 = n_rdreq;
    push(8'h3c, 1'b0);
    push(8'h96, 1'b1);
    repeat (27) @(negedge clk);
    #1 reset_n = 1'b0;
    @(negedge clk);
    check("t5_txd", txd, 1);
    check("t5_busy", busy, 0);
    check("t5_rdreq", fifo_rdreq, 0);
    check("t5_done", byte_done, 0);
    #1 reset_n = 1'b1;
    expect_frames("t5", 1, 200);
    repeat (10) @(negedge clk);
    check("t5_rdreq_count", n_rdreq - rd0, 2);
    check("t5_fifo_drained", fifo_empty, 1);

    // 6: default divider, byte 0x00
    @(negedge clk);
    d_tx_en = 1'b1;
    d_fifo_empty = 1'b0;
    t = 0;
    while (d_rdreq !== 1'b1 && t < 10) begin
      @(negedge clk);
      t++;
    end
    check("t6_rdreq_seen", d_rdreq, 1);
    d_fifo_empty = 1'b1;
    t = 0;
    while (d_txd !== 1'b0 && t < 10) begin
      @(negedge clk);
      t++;
    end
    check("t6_start_seen", d_txd, 0);
    lows = 0;
    while (d_txd === 1'b0 && lows < 5000) begin
      lows++;
      @(negedge clk);
    end
    check("t6_low_len", lows, 3906);
    hi = 1;
    while (d_done !== 1'b1 && hi < 1000) begin
      @(negedge clk);
      hi++;
    end
    check("t6_stop_len", hi, 434);
    check("t6_stop_txd", d_txd, 1);
    @(negedge clk);
    check("t6_done_pulse", d_done, 0);
    check("t6_busy_after", d_busy, 0);
    check("t6_txd_after", d_txd, 1);

    repeat (20) @(negedge clk);
    check("end_no_extra_frames", n_rx - rx_rd, 0);
    check("end_no_rdreq_on_empty", n_bad_rd, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
